// File: rtl/protocore_pkg.sv
// Shared constants and state encoding for the protocore fetch/decode pair.
// Widths here match the 8-bit immediate and 24-bit instruction word.
package protocore_pkg;

  localparam int INSTR_WIDTH = 24;
  localparam int PC_WIDTH    = 8;
  localparam logic [3:0] OPC_HALT = 4'hF;

  typedef enum logic [1:0] {
    STOPPED = 2'b00,
    RUNNING = 2'b01,
    STEP    = 2'b10,
    HALTED  = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// PC / fetch stage with run-step-halt control and a retired-instruction counter.
// imem_addr is the combinational next PC; memory returns mem[pc] one cycle later.
module instruction_fetch
  import protocore_pkg::*;
#(
  parameter int PC_WIDTH    = protocore_pkg::PC_WIDTH,
  parameter int INSTR_WIDTH = protocore_pkg::INSTR_WIDTH,
  parameter int RESET_PC    = 0,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   step,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_WIDTH-1:0]    pc,
  input  logic                   pc_overwrite,
  input  logic [PC_WIDTH-1:0]    target,
  input  logic                   halt,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   instr_count
);

  localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);

  fetch_state_e          state_q;
  fetch_state_e          state_d;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [PC_WIDTH-1:0]   pc_d;
  logic                  valid_w;

  assign valid_w = (state_q == RUNNING) || (state_q == STEP);

  always_comb begin
    state_d = state_q;
    if (valid_w && halt) begin
      state_d = HALTED;
    end else begin
      case (state_q)
        STOPPED: begin
          if (run) begin
            state_d = RUNNING;
          end else if (step) begin
            state_d = STEP;
          end
        end
        RUNNING: begin
          if (!run) begin
            state_d = STOPPED;
          end
        end
        STEP:    state_d = STOPPED;
        HALTED:  state_d = HALTED;
        default: state_d = STOPPED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STOPPED;
    end else begin
      state_q <= state_d;
    end
  end

  // Redirect and halt inputs only matter while a live instruction is on the bus.
  always_comb begin
    pc_d = pc_q + 1'b1;
    if (rst) begin
      pc_d = RESET_PC_V;
    end else if (!valid_w) begin
      pc_d = pc_q;
    end else if (halt) begin
      pc_d = pc_q;
    end else if (pc_overwrite) begin
      pc_d = target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC_V;
    end else begin
      pc_q <= pc_d;
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_instr_count (
    .clk   (clk),
    .clr   (rst),
    .en    (valid_w),
    .count (instr_count)
  );

  assign imem_addr   = pc_d;
  assign pc          = pc_q;
  assign instr_valid = valid_w;
  assign instruction = valid_w ? imem_data : '0;
  assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: behavioural memory and decode stand-in, with a
// scoreboard of expected (pc, instruction) pairs checked on every valid cycle.
module tb_instruction_fetch;
  import protocore_pkg::*;

  localparam logic [3:0] OPC_JMP = 4'h1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [7:0]  imem_addr;
  logic [23:0] imem_data;
  logic [23:0] instruction;
  logic        instr_valid;
  logic [7:0]  pc;
  logic        pc_overwrite;
  logic [7:0]  target;
  logic        halt;
  logic        halted;
  logic [15:0] instr_count;

  logic        ovr_force = 1'b0;
  logic        halt_force = 1'b0;
  logic        sb_on = 1'b0;

  logic [23:0] mem [0:255];

  typedef struct packed {
    logic [7:0]  pc;
    logic [23:0] instr;
  } exp_t;
  exp_t sb_q[$];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= mem[imem_addr];

  assign pc_overwrite = (instruction[23:20] == OPC_JMP) || ovr_force;
  assign target       = ovr_force ? 8'h99 : instruction[7:0];
  assign halt         = (instruction[23:20] == OPC_HALT) || halt_force;

  instruction_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .step         (step),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_overwrite (pc_overwrite),
    .target       (target),
    .halt         (halt),
    .halted       (halted),
    .instr_count  (instr_count)
  );

  // Scoreboard monitor: each valid cycle must match the next expected entry.
  always @(negedge clk) begin
    if (sb_on) begin
      if (instr_valid) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected: valid at pc %h instr %h, want none", pc, instruction);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (pc !== e.pc || instruction !== e.instr) begin
            miscompares++;
            $display("FAIL sb_item: got pc %h instr %h, want pc %h instr %h",
                     pc, instruction, e.pc, e.instr);
          end else begin
            $display("retire pc=%h instr=%h count=%0d", pc, instruction, instr_count);
          end
        end
      end else begin
        vectors++;
        if (instruction !== 24'h0) begin
          miscompares++;
          $display("FAIL idle_instr: got %h want 000000", instruction);
        end
      end
    end
  end

  task automatic init_mem();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      mem[i] = {4'h0, 4'h3, b ^ 8'hA5, b};
    end
  endtask

  task automatic expect_pc(input logic [7:0] p);
    exp_t e;
    e.pc = p;
    e.instr = mem[p];
    sb_q.push_back(e);
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sb_on = 1'b0;
    rst = 1'b1; run = 1'b0; step = 1'b0;
    ovr_force = 1'b0; halt_force = 1'b0;
    sb_q.delete();
    edge1();
    edge1();
    rst = 1'b0;
    sb_on = 1'b1;
  endtask

  task automatic test_reset();
    init_mem();
    rst = 1'b1; run = 1'b1; step = 1'b1;
    edge1();
    edge1();
    vectors += 6;
    if (pc !== 8'h00) begin miscompares++; $display("FAIL rst_pc: got %h want 00", pc); end
    if (imem_addr !== 8'h00) begin miscompares++; $display("FAIL rst_addr: got %h want 00", imem_addr); end
    if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    if (instruction !== 24'h0) begin miscompares++; $display("FAIL rst_instr: got %h want 0", instruction); end
    if (halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted: got %b want 0", halted); end
    if (instr_count !== 16'h0) begin miscompares++; $display("FAIL rst_count: got %h want 0", instr_count); end
    $display("reset pc=%h valid=%b count=%0d", pc, instr_valid, instr_count);
  endtask

  task automatic test_sequential();
    init_mem();
    do_reset();
    for (int i = 0; i < 4; i++) expect_pc(8'(i));
    run = 1'b1;
    repeat (4) edge1();
    run = 1'b0;
    edge1();
    vectors += 4;
    if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL seq_stop: got valid %b want 0", instr_valid); end
    if (instr_count !== 16'd4) begin miscompares++; $display("FAIL seq_count: got %0d want 4", instr_count); end
    if (pc !== 8'd4) begin miscompares++; $display("FAIL seq_pc: got %h want 04", pc); end
    if (sb_q.size() != 0) begin miscompares++; $display("FAIL seq_drain: %0d left want 0", sb_q.size()); end
  endtask

  task automatic test_jump();
    init_mem();
    mem[5] = {OPC_JMP, 12'h000, 8'h20};
    do_reset();
    for (int i = 0; i < 6; i++) expect_pc(8'(i));
    expect_pc(8'h20);
    expect_pc(8'h21);
    run = 1'b1;
    repeat (7) edge1();
    vectors += 2;
    if (pc !== 8'h20) begin miscompares++; $display("FAIL jmp_pc: got %h want 20", pc); end
    if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL jmp_bubble: got valid %b want 1", instr_valid); end
    edge1();
    run = 1'b0;
    edge1();
    vectors++;
    if (sb_q.size() != 0) begin miscompares++; $display("FAIL jmp_drain: %0d left want 0", sb_q.size()); end
  endtask

  task automatic test_halt();
    init_mem();
    mem[3] = {OPC_HALT, 20'h00000};
    do_reset();
    for (int i = 0; i < 4; i++) expect_pc(8'(i));
    run = 1'b1;
    repeat (5) edge1();
    vectors += 4;
    if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_flag: got %b want 1", halted); end
    if (pc !== 8'd3) begin miscompares++; $display("FAIL halt_pc: got %h want 03", pc); end
    if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL halt_valid: got %b want 0", instr_valid); end
    if (instr_count !== 16'd4) begin miscompares++; $display("FAIL halt_count: got %0d want 4", instr_count); end
    step = 1'b1;
    edge1();
    step = 1'b0;
    repeat (3) edge1();
    vectors += 4;
    if (halted !== 1'b1) begin miscompares++; $display("FAIL halt_sticky: got %b want 1", halted); end
    if (pc !== 8'd3) begin miscompares++; $display("FAIL halt_hold: got %h want 03", pc); end
    if (instr_count !== 16'd4) begin miscompares++; $display("FAIL halt_count2: got %0d want 4", instr_count); end
    if (sb_q.size() != 0) begin miscompares++; $display("FAIL halt_drain: %0d left want 0", sb_q.size()); end
    run = 1'b0;
  endtask

  task automatic test_step();
    init_mem();
    mem[0] = {OPC_JMP, 12'h000, 8'h0A};
    do_reset();
    expect_pc(8'h00);
    run = 1'b1;
    edge1();
    run = 1'b0;
    edge1();
    vectors++;
    if (pc !== 8'd10) begin miscompares++; $display("FAIL step_park: got %h want 0a", pc); end
    ovr_force = 1'b1; halt_force = 1'b1;
    repeat (2) edge1();
    vectors += 2;
    if (pc !== 8'd10) begin miscompares++; $display("FAIL step_ignore_ovr: got %h want 0a", pc); end
    if (halted !== 1'b0) begin miscompares++; $display("FAIL step_ignore_halt: got %b want 0", halted); end
    ovr_force = 1'b0; halt_force = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_pc(8'(10 + k));
      step = 1'b1;
      edge1();
      step = 1'b0;
      repeat (3) edge1();
    end
    vectors += 3;
    if (pc !== 8'd13) begin miscompares++; $display("FAIL step_pc: got %h want 0d", pc); end
    if (instr_count !== 16'd4) begin miscompares++; $display("FAIL step_count: got %0d want 4", instr_count); end
    if (sb_q.size() != 0) begin miscompares++; $display("FAIL step_drain: %0d left want 0", sb_q.size()); end
    expect_pc(8'd13);
    expect_pc(8'd14);
    run = 1'b1; step = 1'b1;
    edge1();
    step = 1'b0;
    edge1();
    run = 1'b0;
    edge1();
    vectors += 2;
    if (pc !== 8'd15) begin miscompares++; $display("FAIL runstep_pc: got %h want 0f", pc); end
    if (sb_q.size() != 0) begin miscompares++; $display("FAIL runstep_drain: %0d left want 0", sb_q.size()); end
  endtask

  task automatic test_wrap_saturate();
    init_mem();
    mem[0] = {OPC_JMP, 12'h000, 8'hFF};
    do_reset();
    expect_pc(8'h00);
    expect_pc(8'hFF);
    expect_pc(8'h00);
    run = 1'b1;
    repeat (3) edge1();
    vectors++;
    if (pc !== 8'h00) begin miscompares++; $display("FAIL wrap_pc: got %h want 00", pc); end
    run = 1'b0;
    edge1();
    force dut.u_instr_count.count_q = 16'hFFFC;
    edge1();
    release dut.u_instr_count.count_q;
    edge1();
    init_mem();
    expect_pc(8'hFF);
    for (int i = 0; i < 4; i++) expect_pc(8'(i));
    run = 1'b1;
    repeat (5) edge1();
    run = 1'b0;
    edge1();
    vectors += 2;
    if (instr_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_count: got %h want ffff", instr_count); end
    if (sb_q.size() != 0) begin miscompares++; $display("FAIL wrap_drain: %0d left want 0", sb_q.size()); end
  endtask

  task automatic test_mid_reset();
    init_mem();
    do_reset();
    for (int i = 0; i < 8; i++) expect_pc(8'(i));
    run = 1'b1;
    repeat (8) edge1();
    rst = 1'b1;
    edge1();
    vectors += 5;
    if (pc !== 8'h00) begin miscompares++; $display("FAIL mrst_pc: got %h want 00", pc); end
    if (imem_addr !== 8'h00) begin miscompares++; $display("FAIL mrst_addr: got %h want 00", imem_addr); end
    if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL mrst_valid: got %b want 0", instr_valid); end
    if (instr_count !== 16'h0) begin miscompares++; $display("FAIL mrst_count: got %0d want 0", instr_count); end
    if (sb_q.size() != 0) begin miscompares++; $display("FAIL mrst_drain: %0d left want 0", sb_q.size()); end
    rst = 1'b0; run = 1'b0;
    edge1();
    vectors += 2;
    if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL mrst_stopped: got %b want 0", instr_valid); end
    if (pc !== 8'h00) begin miscompares++; $display("FAIL mrst_pc2: got %h want 00", pc); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_halt();
    test_step();
    test_wrap_saturate();
    test_mid_reset();
    sb_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
